seg_scan_ctrl: RTL and testbench

- Time-multiplexes the Basys3 4-digit 7-segment display to show two letter indices: the plaintext key pressed on the left pair and the Enigma output on the right pair.
- Shares one external AlphabetDecoder instance across all four digits. Drives its 5-bit input and picks its tens (seg1) or ones (seg0) output per digit.
- Sits between the Enigma core output registers and the board pins.
- Takes new letter pairs through a valid/ready handshake and applies them only at frame boundaries, so the display never tears.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_scan_timer.sv | 67 ++++++
 rtl/seg_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package seg_pkg;

  localparam int            LETTER_W   = 5;
  localparam logic [4:0]    LETTER_MAX = 5'd26;

  localparam logic [6:0]    SEG_DASH   = 7'b0111111;  // only segment g lit
  localparam logic [6:0]    SEG_OFF    = 7'h7F;
  localparam logic [3:0]    AN_OFF     = 4'b1111;

  // Digit index; DIG3 is the leftmost display position.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Per-slot phase: anodes dark during GUARD, lit during ON.
  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } slot_st_e;

  // Active-low one-hot anode pattern for a digit.
  function automatic logic [3:0] an_onehot(digit_e d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter, digit index and GUARD/ON phase for the display scan.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  output digit_e dig_o,
  output digit_e dig_nxt_o,
  output logic   on_o,
  output logic   slot_end_o,
  output logic   frame_end_o
);

  localparam int               CNT_W      = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           dig_q, dig_d;
  slot_st_e         st_q, st_d;
  logic             slot_end;

  assign slot_end = (cnt_q == CNT_LAST);

  // Slot counter wraps each slot; digit steps 3->2->1->0->3 at the wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    dig_d = dig_q;
    if (slot_end) begin
      cnt_d = '0;
      dig_d = digit_e'(dig_q - 2'd1);
    end
  end

  // Phase FSM: leave GUARD after its last cycle, return to GUARD at slot end.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_GUARD: if (cnt_q == GUARD_LAST) st_d = ST_ON;
      ST_ON:    if (slot_end)            st_d = ST_GUARD;
      default:                           st_d = ST_GUARD;
    endcase
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dig_q <= DIG3;
      st_q  <= ST_GUARD;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      st_q  <= st_d;
    end
  end

  assign dig_o       = dig_q;
  assign dig_nxt_o   = dig_d;
  assign on_o        = (st_q == ST_ON);
  assign slot_end_o  = slot_end;
  assign frame_end_o = slot_end && (dig_q == DIG0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexes two letter indices onto the 4-digit display through one shared
// decoder; new pairs are accepted by handshake and shown from the next frame.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [LETTER_W-1:0] upd_in_letter,
  input  logic [LETTER_W-1:0] upd_out_letter,
  input  logic                blank,
  output logic [LETTER_W-1:0] dec_in,
  input  logic [6:0]          dec_seg0,
  input  logic [6:0]          dec_seg1,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [3:0]          an
);

  digit_e dig, dig_nxt;
  logic   on, slot_end, frame_end;

  seg_scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYC   (GUARD_CYC)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .dig_o       (dig),
    .dig_nxt_o   (dig_nxt),
    .on_o        (on),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  logic [LETTER_W-1:0] shown_in_q, shown_in_d, shown_out_q, shown_out_d;
  logic [LETTER_W-1:0] sh_in_q, sh_in_d, sh_out_q, sh_out_d;
  logic [LETTER_W-1:0] dec_in_q, dec_in_d;
  logic [6:0]          seg_q, seg_d;
  logic                pend_q, pend_d, rdy_q, rdy_d, blank_q;
  logic                xfer, commit, is_tens;

  // Ready is low whenever a pair is pending, so a transfer and a commit
  // can never land on the same edge.
  assign xfer    = upd_valid && rdy_q;
  assign commit  = frame_end && pend_q;
  assign is_tens = (dig == DIG3) || (dig == DIG1);

  // Handshake, shadow and frame-boundary commit.
  always_comb begin
    shown_in_d  = shown_in_q;
    shown_out_d = shown_out_q;
    sh_in_d     = sh_in_q;
    sh_out_d    = sh_out_q;
    pend_d      = pend_q;
    if (commit) begin
      shown_in_d  = sh_in_q;
      shown_out_d = sh_out_q;
      pend_d      = 1'b0;
    end
    if (xfer) begin
      sh_in_d  = upd_in_letter;
      sh_out_d = upd_out_letter;
      pend_d   = 1'b1;
    end
    rdy_d = !pend_d;
  end

  // Decoder input loads at slot start (using freshly committed letters);
  // segments follow the decoder one cycle later, dashing illegal letters.
  always_comb begin
    dec_in_d = dec_in_q;
    if (slot_end) begin
      if ((dig_nxt == DIG3) || (dig_nxt == DIG2)) dec_in_d = shown_in_d;
      else                                        dec_in_d = shown_out_d;
    end
    if (dec_in_q > LETTER_MAX) seg_d = SEG_DASH;
    else if (is_tens)          seg_d = dec_seg1;
    else                       seg_d = dec_seg0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_in_q  <= '0;
      shown_out_q <= '0;
      sh_in_q     <= '0;
      sh_out_q    <= '0;
      pend_q      <= 1'b0;
      rdy_q       <= 1'b1;
      dec_in_q    <= '0;
      seg_q       <= SEG_OFF;
      blank_q     <= 1'b0;
    end else begin
      shown_in_q  <= shown_in_d;
      shown_out_q <= shown_out_d;
      sh_in_q     <= sh_in_d;
      sh_out_q    <= sh_out_d;
      pend_q      <= pend_d;
      rdy_q       <= rdy_d;
      dec_in_q    <= dec_in_d;
      seg_q       <= seg_d;
      blank_q     <= blank;
    end
  end

  assign upd_ready = rdy_q;
  assign dec_in    = dec_in_q;
  assign seg       = seg_q;
  assign dp        = (dig != DIG2);
  assign an        = (on && !blank_q) ? an_onehot(dig) : AN_OFF;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with REFRESH_DIV=8, GUARD_CYC=2. The model tracks
// time as edges since reset and derives slot/digit/frame by division.
module tb_seg_scan_ctrl;

  localparam int RD = 8;
  localparam int GC = 2;
  localparam int FR = 4 * RD;

  logic       clk, rst_n, upd_valid, upd_ready, blank, dp;
  logic [4:0] upd_in_letter, upd_out_letter, dec_in;
  logic [6:0] dec_seg0, dec_seg1, seg;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;

  // Model state
  int         k;
  logic [4:0] m_in, m_out, sh_in, sh_out;
  bit         m_pend, m_blank;
  int         n_acc;

  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Behavioural stand-in for the shared decoder.
  assign dec_seg1 = font(int'(dec_in) / 10);
  assign dec_seg0 = font(int'(dec_in) % 10);

  seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_in_letter  (upd_in_letter),
    .upd_out_letter (upd_out_letter),
    .blank          (blank),
    .dec_in         (dec_in),
    .dec_seg0       (dec_seg0),
    .dec_seg1       (dec_seg1),
    .seg            (seg),
    .dp             (dp),
    .an             (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; m_in = 0; m_out = 0; sh_in = 0; sh_out = 0;
    m_pend = 0; m_blank = 0;
  endtask

  // Compare every visible output against the model's view of this cycle.
  task automatic check_all();
    int         pos, dg, letter;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    pos  = k % RD;
    dg   = 3 - ((k / RD) % 4);
    e_an = 4'hF;
    if (pos >= GC && !m_blank) e_an[dg] = 1'b0;
    letter = (dg >= 2) ? int'(m_in) : int'(m_out);
    if (letter > 26)               e_seg = 7'b0111111;
    else if (dg == 3 || dg == 1)   e_seg = font(letter / 10);
    else                           e_seg = font(letter % 10);
    chk("an", an, e_an);
    chk("dp", dp, (dg == 2) ? 1'b0 : 1'b1);
    chk("upd_ready", upd_ready, !m_pend);
    chk("dec_in", dec_in, letter);
    if (pos >= 1) chk("seg", seg, e_seg);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic tick();
    bit         xfer;
    logic [4:0] a, b;
    xfer = upd_valid && !m_pend;
    a = upd_in_letter;
    b = upd_out_letter;
    @(posedge clk);
    k++;
    if ((k % FR) == 0 && m_pend) begin
      m_in = sh_in; m_out = sh_out; m_pend = 0;
    end
    if (xfer) begin
      sh_in = a; sh_out = b; m_pend = 1; n_acc++;
    end
    m_blank = blank;
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FR && (k % FR) != ph; i++) tick();
  endtask

  task automatic offer(input logic [4:0] a, input logic [4:0] b);
    upd_in_letter = a; upd_out_letter = b; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    int         acc_k [2];
    logic [4:0] pin [2];
    logic [4:0] pout [2];
    int         idx, prev;

    rst_n = 1'b0; upd_valid = 1'b0; blank = 1'b0;
    upd_in_letter = '0; upd_out_letter = '0; n_acc = 0;
    model_reset();
    #12;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_dec_in", dec_in, 5'd0);
    chk("rst_ready", upd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();

    // One full frame idle: shows 00 00.
    run(FR);

    // Mid-frame transfer of 7/19.
    wait_phase(13);
    offer(5'd7, 5'd19);
    chk("ready_drop", upd_ready, 1'b0);
    run(FR + 8);

    // Back-to-back with valid held: 3/4 then 25/26.
    pin[0] = 5'd3;  pout[0] = 5'd4;
    pin[1] = 5'd25; pout[1] = 5'd26;
    idx = 0;
    wait_phase(5);
    for (int i = 0; i < 3 * FR && idx < 2; i++) begin
      upd_in_letter = pin[idx]; upd_out_letter = pout[idx]; upd_valid = 1'b1;
      prev = n_acc;
      tick();
      if (n_acc != prev) begin acc_k[idx] = k; idx++; end
    end
    upd_valid = 1'b0;
    chk("b2b_both_taken", idx, 2);
    chk("b2b_next_frame", (acc_k[1] - 1) / FR - (acc_k[0] - 1) / FR, 1);
    run(FR + 4);

    // Out-of-range plaintext letter.
    offer(5'd31, 5'd2);
    run(2 * FR);

    // Blank mid-slot across a pending commit.
    wait_phase(26);
    offer(5'd12, 5'd8);
    run(1);
    blank = 1'b1;
    run(20);
    blank = 1'b0;
    run(FR);

    // Reset while pending, in the digit-1 ON phase.
    wait_phase(10);
    offer(5'd21, 5'd15);
    wait_phase(20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_ready", upd_ready, 1'b1);
    chk("arst_dec_in", dec_in, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
    run(2 * FR);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      upd_valid      = ($urandom % 3) == 0;
      upd_in_letter  = 5'($urandom_range(0, 31));
      upd_out_letter = 5'($urandom_range(0, 31));
      if (($urandom % 16) == 0) blank = ~blank;
      tick();
    end
    upd_valid = 1'b0;
    blank = 1'b0;
    run(FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
